chatter_free_counter: RTL and testbench

Parametrised, fully synchronous switch debouncer and event counter. It takes raw mechanical contacts, synchronises and debounces them, and counts each debounced press in an up/down counter of configurable width. It supports a two-contact (SPDT, set/reset latch) mode and a single-contact timed mode, plus selectable wrap or saturate behaviour. It sits between board push-buttons and any logic that needs a clean press count or press strobe.

---
 rtl/chatter_free_counter_if.sv | 24 ++
 rtl/chatter_free_counter.sv | 146 ++++++++++++++
 tb/tb_chatter_free_counter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/chatter_free_counter_if.sv
// rtl/chatter_free_counter_if.sv - contact, control and count signals of the debouncing press counter
interface chatter_free_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             a;
  logic             b;
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             pressed;
  logic             press_pulse;
  logic [WIDTH-1:0] count;
  logic             limit;

  modport master (
    output a, b, en, up_dn, clr,
    input  pressed, press_pulse, count, limit
  );

  modport slave (
    input  a, b, en, up_dn, clr,
    output pressed, press_pulse, count, limit
  );
endinterface

// File: rtl/chatter_free_counter.sv
// rtl/chatter_free_counter.sv - contact synchroniser, debouncer and up/down press counter
module chatter_free_counter #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int DEB_CYCLES  = 1000,
  parameter int SATURATE    = 0
) (
  input logic                  clk,
  input logic                  rst,
  chatter_free_counter_if.slave bus
);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic                   a_s;
  logic                   b_s;
  logic                   pressed_q;
  logic                   pressed_d;
  logic                   press_pulse_q;
  logic                   press_pulse_d;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_d;
  logic                   limit_q;
  logic                   limit_d;
  logic                   step;

  // Shift raw contacts through the synchroniser chains; idle contacts read high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '1;
      b_sync_q <= '1;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b};
    end
  end

  assign a_s = a_sync_q[SYNC_STAGES-1];
  assign b_s = b_sync_q[SYNC_STAGES-1];

  if (MODE == 0) begin : g_latch
    // Set/reset latch on the two contacts; idle or illegal both-low state holds the level.
    always_comb begin
      pressed_d = pressed_q;
      if (!b_s && a_s) begin
        pressed_d = 1'b1;
      end else if (!a_s && b_s) begin
        pressed_d = 1'b0;
      end
    end
  end else begin : g_timed
    localparam int TW = $clog2(DEB_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(DEB_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          cand;
    logic          unused_a;

    // The release contact plays no part in single-contact operation.
    assign unused_a = a_s;

    // Accept a new level only after it has differed from pressed for DEB_CYCLES samples.
    always_comb begin
      cand      = ~b_s;
      timer_d   = timer_q;
      pressed_d = pressed_q;
      if (cand == pressed_q) begin
        timer_d = '0;
      end else if (timer_q == LAST) begin
        pressed_d = cand;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    // Qualification timer register.
    always_ff @(posedge clk) begin
      if (rst) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_d;
      end
    end
  end

  // The strobe marks the cycle in which pressed first reads 1 after a 0.
  assign press_pulse_d = pressed_d & ~pressed_q;

  // Debounced level and its rising-edge strobe register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      pressed_q     <= pressed_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  assign step = press_pulse_q & bus.en;

  // Counter next state: clear wins, then boundary steps, then plain steps.
  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (step) begin
      if (bus.up_dn) begin
        if (count_q == '1) begin
          limit_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          limit_d = 1'b1;
          if (SATURATE == 0) count_d = '1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and limit strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign bus.pressed     = pressed_q;
  assign bus.press_pulse = press_pulse_q;
  assign bus.count       = count_q;
  assign bus.limit       = limit_q;

endmodule

// File: tb/tb_chatter_free_counter.sv
// tb/tb_chatter_free_counter.sv - directed and randomized checks of latch, timed, wrap and saturate behaviour
module tb_chatter_free_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   m_wrap;
  int   m_sat;

  chatter_free_counter_if #(.WIDTH(4)) bus0 ();
  chatter_free_counter_if #(.WIDTH(4)) bus1 ();
  chatter_free_counter_if #(.WIDTH(4)) bus2 ();

  assign bus2.a     = bus0.a;
  assign bus2.b     = bus0.b;
  assign bus2.en    = bus0.en;
  assign bus2.up_dn = bus0.up_dn;
  assign bus2.clr   = bus0.clr;

  chatter_free_counter #(.WIDTH(4), .SYNC_STAGES(2), .MODE(0), .DEB_CYCLES(8), .SATURATE(0))
    u_wrap (.clk(clk), .rst(rst), .bus(bus0));
  chatter_free_counter #(.WIDTH(4), .SYNC_STAGES(2), .MODE(1), .DEB_CYCLES(8), .SATURATE(0))
    u_timed (.clk(clk), .rst(rst), .bus(bus1));
  chatter_free_counter #(.WIDTH(4), .SYNC_STAGES(2), .MODE(0), .DEB_CYCLES(8), .SATURATE(1))
    u_sat (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a 16-value counter, either modular or clamped.
  function automatic int model_next(input int c, input bit sat, input bit en_v,
                                    input bit up_v, input bit clr_v);
    if (clr_v) return 0;
    if (!en_v) return c;
    if (up_v) return sat ? ((c + 1 > 15) ? 15 : c + 1) : (c + 1) % 16;
    return sat ? ((c - 1 < 0) ? 0 : c - 1) : (c + 15) % 16;
  endfunction

  function automatic int model_limit(input int c, input bit en_v, input bit up_v, input bit clr_v);
    if (clr_v || !en_v) return 0;
    return up_v ? int'(c == 15) : int'(c == 0);
  endfunction

  // One clean press and release on the latch-mode pair, checked edge by edge.
  task automatic press(input bit en_v, input bit up_v, input bit clr_v);
    int lw;
    int ls;
    bus0.en    = en_v;
    bus0.up_dn = up_v;
    bus0.clr   = clr_v;
    bus0.b     = 1'b0;
    tick();
    tick();
    check("m0_pressed_e2", bus0.pressed, 0);
    tick();
    check("m0_pulse_e3", bus0.press_pulse, 1);
    check("sat_pulse_e3", bus2.press_pulse, 1);
    lw = model_limit(m_wrap, en_v, up_v, clr_v);
    ls = model_limit(m_sat, en_v, up_v, clr_v);
    m_wrap = model_next(m_wrap, 1'b0, en_v, up_v, clr_v);
    m_sat  = model_next(m_sat, 1'b1, en_v, up_v, clr_v);
    tick();
    check("wrap_count", bus0.count, m_wrap);
    check("wrap_limit", bus0.limit, lw);
    check("sat_count", bus2.count, m_sat);
    check("sat_limit", bus2.limit, ls);
    check("m0_pulse_e4", bus0.press_pulse, 0);
    tick();
    check("wrap_limit_drop", bus0.limit, 0);
    check("sat_limit_drop", bus2.limit, 0);
    bus0.clr = 1'b0;
    bus0.b   = 1'b1;
    bus0.a   = 1'b0;
    tick();
    bus0.a = 1'b1;
    tick();
    tick();
    check("m0_released", bus0.pressed, 0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_wrap = 0;
    m_sat  = 0;
    rst = 1'b1;
    bus0.a = 1'b1; bus0.b = 1'b1; bus0.en = 1'b1; bus0.up_dn = 1'b1; bus0.clr = 1'b0;
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.en = 1'b1; bus1.up_dn = 1'b1; bus1.clr = 1'b0;
    tick();
    tick();
    check("rst_pressed", bus0.pressed, 0);
    check("rst_pulse", bus0.press_pulse, 0);
    check("rst_count", bus0.count, 0);
    check("rst_limit", bus0.limit, 0);
    check("rst_timed_pressed", bus1.pressed, 0);
    check("rst_timed_count", bus1.count, 0);
    rst = 1'b0;
    tick();

    // Latch mode with a bouncing press contact: one strobe at edge 3, count at edge 4.
    for (int e = 1; e <= 10; e++) begin
      bus0.b = (e == 1 || e == 3 || e == 5) ? 1'b0 : ((e <= 7) ? 1'b1 : 1'b1);
      if (e == 2 || e == 4 || e == 6) bus0.b = 1'b1;
      tick();
      check("bounce_pulse", bus0.press_pulse, int'(e == 3));
      check("bounce_pressed", bus0.pressed, int'(e >= 3));
      check("bounce_count", bus0.count, int'(e >= 4));
    end
    m_wrap = 1;
    m_sat  = 1;
    bus0.a = 1'b0;
    tick();
    bus0.a = 1'b1;
    check("rel_pressed_e1", bus0.pressed, 1);
    tick();
    check("rel_pressed_e2", bus0.pressed, 1);
    tick();
    check("rel_pressed_e3", bus0.pressed, 0);
    check("rel_no_pulse", bus0.press_pulse, 0);
    tick();

    // Wrap / saturate at the top, then one down step.
    press(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) press(1'b1, 1'b1, 1'b0);
    check("wrap_top", bus0.count, 0);
    check("sat_top", bus2.count, 15);
    press(1'b1, 1'b0, 1'b0);
    check("wrap_down", bus0.count, 15);
    // Boundary at zero on the way down.
    press(1'b1, 1'b1, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check("sat_bottom", bus2.count, 0);
    // Clear coincident with a step at 7, then a disabled step at 3.
    press(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) press(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b1);
    check("clr_with_step", bus0.count, 0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("en_low_hold", bus0.count, 3);

    // Random control mix against the model.
    for (int i = 0; i < 40; i++) begin
      press(bit'(($urandom % 4) != 0), bit'($urandom % 2), bit'(($urandom % 8) == 0));
    end

    // Timed mode: a 7-cycle low run is rejected, the 20-cycle run qualifies at its edge 10.
    for (int e = 1; e <= 28; e++) begin
      bus1.b = (e == 8) ? 1'b1 : 1'b0;
      tick();
      check("timed_pressed", bus1.pressed, int'(e >= 18));
      check("timed_pulse", bus1.press_pulse, int'(e == 18));
      check("timed_count", bus1.count, int'(e >= 19));
    end
    bus1.b = 1'b1;
    for (int e = 0; e < 12; e++) tick();
    check("timed_released", bus1.pressed, 0);
    check("timed_count_hold", bus1.count, 1);

    // Reset while the timer is at 5 with the button still held.
    bus1.b = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_wrap = 0;
    m_sat  = 0;
    check("midq_pressed", bus1.pressed, 0);
    check("midq_pulse", bus1.press_pulse, 0);
    check("midq_count", bus1.count, 0);
    check("midq_limit", bus1.limit, 0);
    check("midq_wrap_count", bus0.count, 0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("requal_pressed", bus1.pressed, int'(e >= 10));
      check("requal_count", bus1.count, int'(e >= 11));
    end
    bus1.b = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
